// File: rtl/ttl_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter
// that fronts the shared gate.
interface ttl_rr_arbiter_if #(
  parameter int WIDTH_IN    = 8,
  parameter int WIDTH_INDEX = 3
);
  logic [WIDTH_IN-1:0]    Req;
  logic                   Done;
  logic [WIDTH_IN-1:0]    Grant;
  logic [WIDTH_INDEX-1:0] Grant_index;
  logic                   Busy;
  logic                   Timeout;

  // Requester side drives requests and the release strobe.
  modport master (
    output Req,
    output Done,
    input  Grant,
    input  Grant_index,
    input  Busy,
    input  Timeout
  );

  // Arbiter side.
  modport slave (
    input  Req,
    input  Done,
    output Grant,
    output Grant_index,
    output Busy,
    output Timeout
  );
endinterface

// File: rtl/ttl_rr_arbiter.sv
// Round-robin arbiter sharing one wide gate among WIDTH_IN requesters, with
// grant locking, hold-time limit and registered outputs.
module ttl_rr_arbiter #(
  parameter int WIDTH_IN    = 8,
  parameter int WIDTH_INDEX = 3,
  parameter int MAX_HOLD    = 15,
  parameter int DELAY_RISE  = 0,
  parameter int DELAY_FALL  = 0
) (
  input  logic             Clk,
  input  logic             Clear_bar,
  ttl_rr_arbiter_if.slave  bus
);

  localparam int HOLD_W = 8;
  localparam int CAND_W = WIDTH_INDEX + 1;

  // Parameter sanity; delays are transport annotations only and carry no logic.
  if (WIDTH_IN < 2 || WIDTH_IN > 16) begin : g_bad_width
    $error("ttl_rr_arbiter: WIDTH_IN must be in 2..16");
  end
  if ((1 << WIDTH_INDEX) < WIDTH_IN) begin : g_bad_index
    $error("ttl_rr_arbiter: WIDTH_INDEX too narrow for WIDTH_IN");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("ttl_rr_arbiter: MAX_HOLD must be in 1..255");
  end
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
    $error("ttl_rr_arbiter: output delays must be non-negative");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH_IN-1:0]    grant_q, grant_d;
  logic [WIDTH_INDEX-1:0] idx_q, idx_d;
  logic [WIDTH_INDEX-1:0] last_q, last_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   busy_q, busy_d;
  logic                   tmo_q, tmo_d;

  logic                   pick_vld;
  logic [WIDTH_INDEX-1:0] pick_idx;
  logic [CAND_W-1:0]      cand;

  logic                   rel_done;
  logic                   rel_drop;
  logic                   rel_tmo;

  // Rotating-priority search: first set request at last+1, last+2, ... mod WIDTH_IN.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= WIDTH_IN; i++) begin
      cand = {1'b0, last_q} + CAND_W'(i);
      if (cand >= CAND_W'(WIDTH_IN)) begin
        cand = cand - CAND_W'(WIDTH_IN);
      end
      if (!pick_vld && bus.Req[cand[WIDTH_INDEX-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[WIDTH_INDEX-1:0];
      end
    end
  end

  assign rel_done = bus.Done;
  assign rel_drop = !bus.Req[idx_q];
  assign rel_tmo  = (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = {{(WIDTH_IN-1){1'b0}}, 1'b1} << pick_idx;
          idx_d   = pick_idx;
          hold_d  = '0;
          busy_d  = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_tmo) begin
          grant_d = '0;
          busy_d  = 1'b0;
          last_d  = idx_q;
          state_d = IDLE;
          // Timeout flags only a release forced purely by the hold limit.
          tmo_d   = rel_tmo && !rel_done && !rel_drop;
        end else if (hold_q != {HOLD_W{1'b1}}) begin
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= WIDTH_INDEX'(WIDTH_IN - 1);
      hold_q  <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.Grant       = grant_q;
  assign bus.Grant_index = idx_q;
  assign bus.Busy        = busy_q;
  assign bus.Timeout     = tmo_q;

endmodule

// File: doc/ttl_rr_arbiter.md
# ttl_rr_arbiter

Round-robin arbiter that shares one wide gate resource, such as an 8-input NAND, among up to WIDTH_IN requesters. It sits in front of the shared gate and selects one requester at a time using a rotating priority pointer. A grant stays locked until the owner releases it or a hold-time limit expires. Outputs are registered and carry the same rise/fall delay parameters as the gate models.

## Interface
- WIDTH_IN, 8: number of requesters (2..16)
- WIDTH_INDEX, 3: width of Grant_index; 2**WIDTH_INDEX >= WIDTH_IN required
- MAX_HOLD, 15: maximum cycles a grant may be held before forced release (1..255)
- DELAY_RISE, 0: output rise delay (simulation only)
- DELAY_FALL, 0: output fall delay (simulation only)

- Clk  input  1  clock; all state changes on rising edge
- Clear_bar  input  1  reset; asynchronous and active-low
- Req  input  WIDTH_IN  request lines, one per requester, active-high level
- Done  input  1  release strobe from the current owner, sampled only in GRANT
- Grant  output  WIDTH_IN  one-hot grant, all-zero when idle
- Grant_index  output  WIDTH_INDEX  binary index of the owner; holds the last owner when idle
- Busy  output  1  high while any grant is active (equal to the OR of Grant)
- Timeout  output  1  one-cycle pulse on a forced release

## Operation
- Two states: IDLE and GRANT. Internal pointer `last` holds the index of the most recent owner.
- Reset (Clear_bar low, takes effect immediately regardless of Clk):
  - state=IDLE, Grant=0, Busy=0, Timeout=0, Grant_index=0
  - `last`=WIDTH_IN-1, so requester 0 has highest priority after reset
  - hold counter=0
- IDLE:
  - If Req is nonzero, choose the first set bit scanning `last`+1, `last`+2, … modulo WIDTH_IN.
  - Register Grant to the one-hot of the chosen bit and Grant_index to its index. Clear the hold counter and go to GRANT.
  - If Req is zero, stay in IDLE.
- GRANT: release occurs on the first edge at which any of these holds:
  - (a) Done=1
  - (b) Req[Grant_index]=0, meaning the owner dropped its request
  - (c) hold counter = MAX_HOLD-1
- On release:
  - Grant=0, `last`=Grant_index, state=IDLE.
  - Timeout=1 for one cycle only when (c) is the cause and (a) and (b) are both false.
- Otherwise in GRANT the hold counter increments by 1 and saturates; it never wraps.
- After every release there is exactly one IDLE cycle before the next grant. This guarantees at most one bit set in Grant, even across the output delays.
- Req bits of non-owners are ignored in GRANT. Changes to them have no effect until the next IDLE arbitration.
- Req changes in the same cycle as a release are seen by the following IDLE arbitration.
- Fairness: a continuously asserting requester waits at most WIDTH_IN-1 grants.

## Timing
- Arbitration latency: Req sampled high in IDLE at edge N gives Grant valid after edge N, i.e. 1 cycle.
- Release latency: Done high at edge M gives Grant=0 after edge M. The earliest next grant is after edge M+1.
- Maximum hold: Grant is high for at most MAX_HOLD cycles.
- Reset asserted mid-grant clears Grant asynchronously. Arbitration after reset restarts from requester 0 and ignores the pre-reset pointer.
- On reset deassertion, the first edge with Clear_bar high and Req nonzero performs arbitration.
- DELAY_RISE/DELAY_FALL apply to every output; they are transport annotations only and do not affect cycle behaviour.

## Test plan
- Reset then single request: hold Clear_bar=0, set Req=8'h10, release reset → one edge later Grant=8'h10, Grant_index=4, Busy=1, Timeout=0.
- Rotation: Req=8'hFF held, Done pulsed 1 cycle each time Busy=1 → grant sequence is indices 0,1,2,…,7,0, with one Busy=0 cycle between grants.
- Pointer skip: after owner 5 releases, Req=8'h21 → next Grant=8'h01 (index 0, wraps past 7), not index 5.
- Forced release: MAX_HOLD=4, Req=8'h02 held, Done=0 → Grant=8'h02 for exactly 4 cycles, then Grant=0 with Timeout=1 for one cycle; Grant=8'h02 returns one cycle later.
- Owner drop vs Done: owner index 3 drops Req[3] with Done=0 → Grant=0 next edge, Timeout=0. Done and timeout in the same cycle → Timeout=0.
- Async reset mid-grant: Grant=8'h40, pull Clear_bar low between edges → Grant=0 and Busy=0 immediately without a clock; after release with Req=8'hC0, Grant=8'h40 (index 6, scan restarts at 0).
